mul4x4_arbiter: RTL
===================

# mul4x4_arbiter

Time-shares a single `mul4x4` array multiplier between `NREQ` independent requesters. Each requester presents 4-bit unsigned operands under a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the product returns on a single tagged response channel with its own valid/ready handshake. The block sits between the client units and the one combinational multiplier instance, so that only one `mul4x4` is built.

## Interface
- `NREQ`, default 2: number of requesters; legal range 2..8.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset. Synchronous, active-low.
- `req_valid`  in  NREQ: bit i set means requester i presents operands.
- `req_ready`  out  NREQ: bit i set means requester i's operands are accepted this cycle. One-hot or zero.
- `req_x`  in  4*NREQ: operand x of requester i on bits [4i+3:4i].
- `req_y`  in  4*NREQ: operand y of requester i on bits [4i+3:4i].
- `rsp_valid`  out  1: response slot holds a result.
- `rsp_ready`  in  1: consumer takes the response this cycle.
- `rsp_id`  out  IDW: index of the requester that owns `rsp_out`. IDW = max(1, clog2(NREQ)).
- `rsp_out`  out  8: unsigned product x*y.

## Operation
- Accept occurs on requester i when `req_valid[i] & req_ready[i]`. Response occurs when `rsp_valid & rsp_ready`.
- The pipeline can advance (`adv`) when the output slot is empty or is being drained this cycle: `adv = !rsp_valid | rsp_ready`.
- Grant rule:
  - Round-robin over asserted `req_valid` bits, searching from `last+1` modulo NREQ.
  - `req_ready[i] = adv & grant[i]`.
  - `last` updates to i only on an accept.
  - With no valid request, there is no grant and `last` holds.
- Datapath: the granted operands drive the shared `mul4x4` (`x`, `y`, `out`). The product and granted index are captured into the output slot on accept.
- Result width: the full 8-bit product; no truncation or overflow is possible (15*15 = 225).
- Slot state:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on a response with no accept in the same cycle.
  - FULL → FULL on a response with a simultaneous accept: the new result replaces the old one in the same cycle.
  - FULL with `!rsp_ready`: all fields hold stable and every `req_ready` is 0.
- A requester whose valid drops before being granted loses nothing. Requesters must hold their operands stable until accepted.
- Reset:
  - `rsp_valid` = 0, `rsp_out` = 0, `rsp_id` = 0.
  - `last` = NREQ-1, so requester 0 wins first.
  - `req_ready` forced to 0 while `rst_n` = 0.
  - Reset mid-operation discards any held result with no response emitted.

## Timing
- Base configuration:
  - Latency 1: accept at edge n gives `rsp_valid` from n+1.
  - Throughput is 1 result per cycle while `rsp_ready` stays high.
- With pipelining enabled (see Configuration):
  - Latency 2.
  - Throughput is still 1 per cycle.
- `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and the internal state. There is no combinational path from operands to ready.
- Fairness: with all requesters continuously valid and no backpressure, each requester is served exactly once every NREQ cycles.

## Configuration
- `MUL4X4_ARBITER_PIPE_EN` defined:
  - An operand register stage (x, y, id, stage-valid) is inserted before `mul4x4`, cutting the path from the arbiter to the multiplier.
  - Both stages advance together on `adv`, so backpressure stalls the whole pipeline with no data loss.
  - An empty operand stage does not block accepts.
  - Reset clears the operand stage-valid flag.
- Undefined: operands feed `mul4x4` directly from the granted requester; latency 1.

## Structure
- Package `mul4x4_arbiter_pkg` holds:
  - `OPW` = 4, `RESW` = 8.
  - The `IDW` computation function.
  - The response struct typedef `{id, product}`.
- Sub-module `rr_arbiter` (parameter `NREQ`): inputs `req`, `advance`, `clk`, `rst_n`; outputs one-hot `grant` and encoded index. It owns the `last` pointer.
- Exactly one `mul4x4` instance, used unchanged.

## Test plan
- Single request from requester 0 with x=4, y=8 → one cycle later `rsp_valid`=1, `rsp_out`=32, `rsp_id`=0.
- Single request from requester 1 with x=5, y=3 → `rsp_out`=15, `rsp_id`=1.
- Requester 1 with x=15, y=15 → `rsp_out`=225. Then x=0, y=9 → `rsp_out`=0.
- Requesters 0 (x=2, y=3) and 1 (x=7, y=7) continuously valid from reset with `rsp_ready`=1 → responses alternate 6 (id 0), 49 (id 1), 6, 49, …
- Requester 0 x=3, y=3 accepted, then `rsp_ready`=0 for 3 cycles while requester 1 is valid:
  - `rsp_out`=9 holds and `req_ready`=0 throughout.
  - `rsp_ready`=1 → requester 1 is accepted in the same cycle.
- `rst_n`=0 asserted while `rsp_valid`=1 → next edge: `rsp_valid`=0, `rsp_out`=0. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/mul4x4_arbiter_pkg.sv
// Shared widths, ID-width helper and response slot type for mul4x4_arbiter.
package mul4x4_arbiter_pkg;

  localparam int unsigned OPW     = 4;
  localparam int unsigned RESW    = 8;
  localparam int unsigned IDW_MAX = 3;

  function automatic int unsigned idw_f(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_e;

  // id is sized for the largest legal NREQ; the top exposes only the low IDW bits
  typedef struct packed {
    logic [IDW_MAX-1:0] id;
    logic [RESW-1:0]    product;
  } rsp_t;

endpackage

// File: rtl/mul4x4.sv
// Combinational 4x4 unsigned array multiplier shared by the arbiter.
module mul4x4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] out
);

  assign out = x * y;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last+1, pointer moves only when the grant is taken.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] last_q, last_d;

  always_comb begin
    logic        found;
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance && (|req)) last_d = grant_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= IDW'(NREQ - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mul4x4_arbiter.sv
// Time-shares one mul4x4 between NREQ requesters with a single tagged response slot.
// Define MUL4X4_ARBITER_PIPE_EN to add an operand register stage ahead of the multiplier.
module mul4x4_arbiter
  import mul4x4_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = idw_f(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [OPW*NREQ-1:0] req_x,
  input  logic [OPW*NREQ-1:0] req_y,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [RESW-1:0]     rsp_out
);

  slot_state_e     state_q, state_d;
  rsp_t            slot_q, slot_d;
  logic            adv, accept, load;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx, load_id;
  logic [OPW-1:0]  gnt_x, gnt_y, mul_x, mul_y;
  logic [RESW-1:0] mul_out;

  assign adv       = (state_q == SLOT_EMPTY) | rsp_ready;
  assign accept    = adv & rst_n & (|grant);
  assign req_ready = (adv & rst_n) ? grant : '0;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (adv),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    gnt_x = '0;
    gnt_y = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_x = gnt_x | req_x[i*OPW +: OPW];
        gnt_y = gnt_y | req_y[i*OPW +: OPW];
      end
    end
  end

`ifdef MUL4X4_ARBITER_PIPE_EN
  logic           st_valid_q, st_valid_d;
  logic [OPW-1:0] st_x_q, st_x_d, st_y_q, st_y_d;
  logic [IDW-1:0] st_id_q, st_id_d;

  // Operand stage shares adv with the slot so a stall freezes both together
  always_comb begin
    st_valid_d = st_valid_q;
    st_x_d     = st_x_q;
    st_y_d     = st_y_q;
    st_id_d    = st_id_q;
    if (adv) begin
      st_valid_d = accept;
      st_x_d     = gnt_x;
      st_y_d     = gnt_y;
      st_id_d    = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_valid_q <= 1'b0;
      st_x_q     <= '0;
      st_y_q     <= '0;
      st_id_q    <= '0;
    end else begin
      st_valid_q <= st_valid_d;
      st_x_q     <= st_x_d;
      st_y_q     <= st_y_d;
      st_id_q    <= st_id_d;
    end
  end

  assign mul_x   = st_x_q;
  assign mul_y   = st_y_q;
  assign load    = st_valid_q;
  assign load_id = st_id_q;
`else
  assign mul_x   = gnt_x;
  assign mul_y   = gnt_y;
  assign load    = accept;
  assign load_id = grant_idx;
`endif

  mul4x4 u_mul (
    .x   (mul_x),
    .y   (mul_y),
    .out (mul_out)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (adv) begin
      if (load) begin
        state_d        = SLOT_FULL;
        slot_d.id      = IDW_MAX'(load_id);
        slot_d.product = mul_out;
      end else begin
        state_d = SLOT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  assign rsp_valid = (state_q == SLOT_FULL);
  assign rsp_id    = slot_q.id[IDW-1:0];
  assign rsp_out   = slot_q.product;

endmodule
